mux_out_skid_16: RTL and testbench

//  Registered output stage directly downstream of the 16-bit 2:1 data mux.

---
 rtl/mux_out_skid_16.sv | 117 +++++++++++
 tb/tb_mux_out_skid_16.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_out_skid_16.sv
// Registered output stage behind the 16-bit 2:1 data mux: 2-entry skid buffer with valid/ready.
// Optional transfer counter port xfer_count is built when XFER_COUNT_EN is defined.
module mux_out_skid_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_key,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_key,
    output logic             out_valid,
    input  logic             out_ready
`ifdef XFER_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    // Handshake: a word moves on a side only in a cycle where its valid and ready are both 1;
    // in_ready/out_valid come from registers only, never from in_* or out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             live;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] main_data_nxt;
    logic             main_key;
    logic             main_key_nxt;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_data_nxt;
    logic             skid_key;
    logic             skid_key_nxt;
    logic             in_fire;
    logic             out_fire;

    // live holds in_ready low until the first edge after reset is released
    assign in_ready  = live & (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_key   = main_key;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_key_nxt  = main_key;
        skid_data_nxt = skid_data;
        skid_key_nxt  = skid_key;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt     = ONE;
                    main_data_nxt = in_data;
                    main_key_nxt  = in_key;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_nxt = in_data;
                    main_key_nxt  = in_key;
                end else if (in_fire) begin
                    state_nxt     = TWO;
                    skid_data_nxt = in_data;
                    skid_key_nxt  = in_key;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nxt     = ONE;
                    main_data_nxt = skid_data;
                    main_key_nxt  = skid_key;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            live      <= 1'b0;
            main_data <= '0;
            main_key  <= 1'b0;
            skid_data <= '0;
            skid_key  <= 1'b0;
        end else begin
            state     <= state_nxt;
            live      <= 1'b1;
            main_data <= main_data_nxt;
            main_key  <= main_key_nxt;
            skid_data <= skid_data_nxt;
            skid_key  <= skid_key_nxt;
        end
    end

`ifdef XFER_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= 16'd0;
        end else if (out_fire) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_out_skid_16.sv
// Bench for mux_out_skid_16: a queue-based FIFO model checked every cycle, plus directed literal checks.
// Define XFER_COUNT_EN for both files to exercise the transfer counter.
module tb_mux_out_skid_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_key;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_key;
    logic        out_valid;
    logic        out_ready;
`ifdef XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    int n_cmp;
    int n_bad;

    mux_out_skid_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_key   (out_key),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef XFER_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: a FIFO of capacity 2, accepting only from the first edge after reset release
    logic [16:0] exp_q[$];
    bit          m_live;
    logic [15:0] m_cnt;

    function automatic bit m_in_ready();
        return m_live && (exp_q.size() < 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_live = 1'b0;
            m_cnt  = 16'd0;
        end else begin
            bit do_in;
            bit do_out;
            do_in  = in_valid && m_in_ready();
            do_out = out_ready && (exp_q.size() > 0);
            if (do_out) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (do_in) exp_q.push_back({in_key, in_data});
            m_live = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin
        check("cyc_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        check("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
        if (exp_q.size() > 0) begin
            check("cyc_out_word", {15'd0, out_key, out_data}, {15'd0, exp_q[0]});
        end else if (!rst_n) begin
            check("cyc_rst_word", {15'd0, out_key, out_data}, 32'd0);
        end
`ifdef XFER_COUNT_EN
        check("cyc_xfer_count", {16'd0, xfer_count}, {16'd0, m_cnt});
`endif
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic k, input logic r);
        in_valid  = v;
        in_data   = v ? d : 16'hDEAD;
        in_key    = v ? k : 1'b1;
        out_ready = r;
    endtask

    // mixed pattern: {in_valid, out_ready} per cycle
    logic [1:0] pat [12] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10,
                             2'b00, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #2;
        check("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
        step();
        check("rel_in_ready_post_edge", {31'd0, in_ready}, 32'd1);

        // single word
        drive(1'b1, 16'hA5A5, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data", {16'd0, out_data}, 32'h0000A5A5);
        check("single_key", {31'd0, out_key}, 32'd1);
        out_ready = 1'b1;
        step();
        check("single_drained", {31'd0, out_valid}, 32'd0);

        // stream of 8 words
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), i[0], 1'b1);
            step();
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check("stream_data", {16'd0, out_data}, i);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // backpressure
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h2222, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h9999, 1'b0, 1'b0);
        step();
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold", {16'd0, out_data}, 32'h00001111);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        check("bp_second", {15'd0, out_key, out_data}, 32'h00012222);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // simultaneous in/out fire in ONE
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'hCAFE, 1'b0, 1'b1);
        check("sim_before", {16'd0, out_data}, 32'h0000BEEF);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("sim_data", {15'd0, out_key, out_data}, 32'h0000CAFE);
        check("sim_still_one", {30'd0, in_ready, out_valid}, 32'd3);
        out_ready = 1'b1;
        step();

        // mixed pattern, model-checked
        foreach (pat[j]) begin
            drive(pat[j][1], 16'h5000 + 16'(j), j[1], pat[j][0]);
            step();
        end

        // reset mid-stream with two words held
        drive(1'b1, 16'h3333, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h4444, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("mid_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_data", {15'd0, out_key, out_data}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("mid_rel_pre_edge", {31'd0, in_ready}, 32'd0);
        step();
        check("mid_rel_ready", {30'd0, in_ready, out_valid}, 32'd2);

`ifdef XFER_COUNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("cnt_reset", {16'd0, xfer_count}, 32'd0);
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 16'(i), i[0], 1'b1);
            step();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        check("cnt_wrap", {16'd0, xfer_count}, 32'd1);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
